// File: rtl/bus_b_pkg.sv
// rtl/bus_b_pkg.sv - shared encodings for the bus-B source stage
//
// Purpose: source-mode encodings for mb and the skid buffer occupancy states.
// Ports: none (package).
package bus_b_pkg;

  typedef enum logic [1:0] {
    MB_REG   = 2'b00,
    MB_CONST = 2'b01,
    MB_ZERO  = 2'b10,
    MB_HOLD  = 2'b11
  } mb_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/bus_b_skid.sv
// rtl/bus_b_skid.sv - two-entry valid/ready skid buffer
//
// Purpose: registers operands and keeps up to two in strict FIFO order so the
//          consumer can stall without loss. in_ready depends on state only.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_data/in_valid/in_ready     upstream handshake
//   out_data/out_valid/out_ready  downstream handshake
module bus_b_skid
  import bus_b_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  skid_state_t      state;
  skid_state_t      state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             consume;
  logic             load_main;
  logic             load_skid;
  logic             main_from_skid;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && !consume) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (!accept && consume) begin
          state_nxt = EMPTY;
        end else if (accept && consume) begin
          // Occupancy unchanged; the new operand replaces the one leaving.
          load_main = 1'b1;
        end
      end
      TWO: begin
        if (consume) begin
          state_nxt      = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_main) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/bus_b_source_stage.sv
// rtl/bus_b_source_stage.sv - registered bus-B operand selector with skid buffer
//
// Purpose: on each accepted request picks the bus-B operand from a register
//          read port, the instruction constant, zero, or the last issued
//          operand, and passes it through a two-entry skid buffer.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   reg_src           NSRC flattened register read ports, port k at [k*WIDTH +: WIDTH]
//   cs                constant field
//   mb                source mode (REG/CONST/ZERO/HOLD)
//   sel_b             register port index (REG mode only)
//   in_valid/in_ready request handshake
//   bus_b/bus_b_valid/bus_b_ready  operand handshake to the function unit
//   sel_err           sticky out-of-range REG select flag
module bus_b_source_stage
  import bus_b_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NSRC  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NSRC*WIDTH-1:0]   reg_src,
  input  logic [WIDTH-1:0]        cs,
  input  logic [1:0]              mb,
  input  logic [$clog2(NSRC)-1:0] sel_b,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        bus_b,
  output logic                    bus_b_valid,
  input  logic                    bus_b_ready,
  output logic                    sel_err
);

  logic [WIDTH-1:0] last_issued;
  logic [WIDTH-1:0] reg_op;
  logic [WIDTH-1:0] operand;
  logic             sel_bad;
  logic             accept;

  assign accept = in_valid && in_ready;

  // sel_b can encode indices beyond NSRC when NSRC is not a power of two;
  // those select zero and flag an error instead of reading past reg_src.
  always_comb begin
    reg_op  = '0;
    sel_bad = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      if (32'(sel_b) == k) begin
        reg_op  = reg_src[k*WIDTH +: WIDTH];
        sel_bad = 1'b0;
      end
    end
  end

  // HOLD reads the register, i.e. the value from the previous accept.
  always_comb begin
    operand = '0;
    case (mb)
      MB_REG:   operand = reg_op;
      MB_CONST: operand = cs;
      MB_ZERO:  operand = '0;
      MB_HOLD:  operand = last_issued;
      default:  operand = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_issued <= '0;
      sel_err     <= 1'b0;
    end else if (accept) begin
      last_issued <= operand;
      if ((mb == MB_REG) && sel_bad) begin
        sel_err <= 1'b1;
      end
    end
  end

  bus_b_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (operand),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (bus_b),
    .out_valid(bus_b_valid),
    .out_ready(bus_b_ready)
  );

endmodule

// File: tb/tb_bus_b_source_stage.sv
// tb/tb_bus_b_source_stage.sv - self-checking bench for bus_b_source_stage
module tb_bus_b_source_stage;

  localparam logic [1:0] M_REG   = 2'b00;
  localparam logic [1:0] M_CONST = 2'b01;
  localparam logic [1:0] M_ZERO  = 2'b10;
  localparam logic [1:0] M_HOLD  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] reg_src;
  logic [23:0] reg_src3;
  logic [7:0]  cs;
  logic [1:0]  mb;
  logic [1:0]  sel_b;
  logic        in_valid;
  logic        bus_b_ready;

  logic        in_ready, bus_b_valid, sel_err;
  logic [7:0]  bus_b;
  logic        in_ready3, bus_b_valid3, sel_err3;
  logic [7:0]  bus_b3;

  logic [7:0]  exp_q[$];
  logic [7:0]  m_last;
  int          checks = 0;
  int          errors = 0;
  logic        acc;

  always #5 clk = ~clk;

  bus_b_source_stage #(.WIDTH(8), .NSRC(4)) dut (
    .clk(clk), .rst_n(rst_n), .reg_src(reg_src), .cs(cs), .mb(mb),
    .sel_b(sel_b), .in_valid(in_valid), .in_ready(in_ready), .bus_b(bus_b),
    .bus_b_valid(bus_b_valid), .bus_b_ready(bus_b_ready), .sel_err(sel_err)
  );

  bus_b_source_stage #(.WIDTH(8), .NSRC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .reg_src(reg_src3), .cs(cs), .mb(mb),
    .sel_b(sel_b), .in_valid(in_valid), .in_ready(in_ready3), .bus_b(bus_b3),
    .bus_b_valid(bus_b_valid3), .bus_b_ready(bus_b_ready), .sel_err(sel_err3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] model_op(input logic [1:0] m, input logic [1:0] s,
                                          input logic [7:0] c);
    case (m)
      M_REG:   return reg_src[s*8 +: 8];
      M_CONST: return c;
      M_ZERO:  return 8'h00;
      default: return m_last;
    endcase
  endfunction

  // One clock: drive at negedge, score the handshakes that the coming posedge
  // will see, then return at the following negedge.
  task automatic cyc(input logic v, input logic [1:0] m, input logic [1:0] s,
                     input logic [7:0] c, input logic r, output logic accepted);
    logic [7:0] op;
    in_valid = v; mb = m; sel_b = s; cs = c; bus_b_ready = r;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
    check("valid", {31'd0, bus_b_valid}, {31'd0, exp_q.size() != 0});
    if (bus_b_valid && bus_b_ready) begin
      if (exp_q.size() == 0) check("underflow", 32'd1, 32'd0);
      else check("sb_data", {24'd0, bus_b}, {24'd0, exp_q.pop_front()});
    end
    accepted = v && in_ready;
    if (accepted) begin
      op = model_op(m, s, c);
      exp_q.push_back(op);
      m_last = op;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, M_ZERO, 2'd0, 8'h00, 1'b1, acc);
  endtask

  task automatic send(input logic [1:0] m, input logic [1:0] s, input logic [7:0] c,
                      input logic r);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) cyc(1'b1, m, s, c, r, a);
    if (!a) check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; reg_src = 32'h44332211; reg_src3 = 24'h332211;
    cs = 8'h00; mb = M_ZERO; sel_b = 2'd0; in_valid = 1'b0; bus_b_ready = 1'b0;
    m_last = 8'h00;
    @(negedge clk); @(negedge clk);
    check("rst_valid", {31'd0, bus_b_valid}, 32'd0);
    check("rst_bus_b", {24'd0, bus_b}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_sel_err", {31'd0, sel_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming at full rate
    cyc(1'b1, M_REG, 2'd2, 8'h00, 1'b1, acc);
    check("str0", {24'd0, bus_b}, 32'h33);
    cyc(1'b1, M_CONST, 2'd0, 8'hA5, 1'b1, acc);
    check("str1", {24'd0, bus_b}, 32'hA5);
    cyc(1'b1, M_ZERO, 2'd0, 8'h00, 1'b1, acc);
    check("str2", {24'd0, bus_b}, 32'h00);
    cyc(1'b1, M_HOLD, 2'd0, 8'h00, 1'b1, acc);
    check("str3", {24'd0, bus_b}, 32'h00);
    check("str3_valid", {31'd0, bus_b_valid}, 32'd1);
    idle(3);

    // Back-pressure: two accepted, then full
    cyc(1'b1, M_CONST, 2'd0, 8'h01, 1'b0, acc);
    check("bp_acc1", {31'd0, acc}, 32'd1);
    cyc(1'b1, M_CONST, 2'd0, 8'h02, 1'b0, acc);
    check("bp_acc2", {31'd0, acc}, 32'd1);
    cyc(1'b1, M_CONST, 2'd0, 8'h03, 1'b0, acc);
    check("bp_full", {31'd0, acc}, 32'd0);
    send(M_CONST, 2'd0, 8'h03, 1'b1);
    idle(4);
    check("bp_drained", {31'd0, bus_b_valid}, 32'd0);

    // Simultaneous accept and consume in ONE
    cyc(1'b1, M_CONST, 2'd0, 8'h10, 1'b0, acc);
    check("sim_hold", {24'd0, bus_b}, 32'h10);
    cyc(1'b1, M_CONST, 2'd0, 8'h20, 1'b1, acc);
    check("sim_bus_b", {24'd0, bus_b}, 32'h20);
    check("sim_ready", {31'd0, in_ready}, 32'd1);
    check("sim_valid", {31'd0, bus_b_valid}, 32'd1);
    idle(3);

    // HOLD chain with register contents changing underneath
    cyc(1'b1, M_REG, 2'd1, 8'h00, 1'b1, acc);
    check("hold0", {24'd0, bus_b}, 32'h22);
    cyc(1'b1, M_HOLD, 2'd0, 8'h00, 1'b1, acc);
    check("hold1", {24'd0, bus_b}, 32'h22);
    reg_src = 32'h99887766;
    cyc(1'b1, M_HOLD, 2'd0, 8'h00, 1'b1, acc);
    check("hold2", {24'd0, bus_b}, 32'h22);
    idle(3);

    // Select error on the three-port instance
    cyc(1'b1, M_REG, 2'd3, 8'h00, 1'b1, acc);
    check("sel_op", {24'd0, bus_b3}, 32'h00);
    check("sel_valid", {31'd0, bus_b_valid3}, 32'd1);
    check("sel_err3", {31'd0, sel_err3}, 32'd1);
    check("sel_err4", {31'd0, sel_err}, 32'd0);
    cyc(1'b1, M_CONST, 2'd0, 8'h55, 1'b1, acc);
    check("sel_next", {24'd0, bus_b3}, 32'h55);
    check("sel_sticky1", {31'd0, sel_err3}, 32'd1);
    cyc(1'b1, M_REG, 2'd1, 8'h00, 1'b1, acc);
    check("sel_reg1", {24'd0, bus_b3}, 32'h22);
    check("sel_sticky2", {31'd0, sel_err3}, 32'd1);
    idle(3);

    // Reset mid-stream with two operands buffered
    cyc(1'b1, M_CONST, 2'd0, 8'h81, 1'b0, acc);
    cyc(1'b1, M_CONST, 2'd0, 8'h82, 1'b0, acc);
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus_b_valid}, 32'd0);
    check("arst_bus_b", {24'd0, bus_b}, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd1);
    check("arst_sel_err3", {31'd0, sel_err3}, 32'd0);
    check("arst_valid3", {31'd0, bus_b_valid3}, 32'd0);
    exp_q.delete();
    m_last = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, M_HOLD, 2'd0, 8'h00, 1'b1, acc);
    check("post_rst_hold", {24'd0, bus_b}, 32'h00);
    check("post_rst_valid", {31'd0, bus_b_valid}, 32'd1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_b_source_stage.md
# bus_b_source_stage

Parametrised, registered successor to the datapath bus-B operand selector. Each accepted request picks the bus-B operand from one of NSRC register-file read ports, the instruction constant, zero, or the last issued operand, and registers it. The result passes through a two-entry skid buffer with valid/ready handshakes, so the function unit can stall without losing operands. The block sits between the register-file read ports / control word and the function unit's B input.

## Interface
- WIDTH, 8, operand width in bits (≥ 1)
- NSRC, 4, number of register read ports selectable (2..16)
- SEL_W, $clog2(NSRC), width of sel_b (derived, not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- reg_src  in  NSRC*WIDTH  flattened register ports; port k at bits [k*WIDTH +: WIDTH]
- cs  in  WIDTH  constant field from the control word
- mb  in  2  source mode: 00 REG, 01 CONST, 10 ZERO, 11 HOLD
- sel_b  in  SEL_W  register port index, used only in REG mode
- in_valid  in  1  request present this cycle
- in_ready  out  1  stage can accept a request
- bus_b  out  WIDTH  operand to function unit
- bus_b_valid  out  1  bus_b holds a valid operand
- bus_b_ready  in  1  function unit consumes bus_b this cycle
- sel_err  out  1  sticky: a REG request had sel_b ≥ NSRC

## Operation
- Accept = in_valid && in_ready. Operand is evaluated from current-cycle inputs at accept:
  - REG: reg_src port sel_b; if sel_b ≥ NSRC, operand = 0 and sel_err sets.
  - CONST: cs. ZERO: all zeros.
  - HOLD: last_issued. Unsigned, no extension; WIDTH bits pass through unchanged.
- last_issued updates to the operand of every accepted request, including HOLD, which re-writes the same value. Reset value 0.
- Skid buffer, states EMPTY, ONE (main valid), TWO (main + skid valid):
  - EMPTY: accept → ONE, main = operand.
  - ONE: accept and no consume → TWO, skid = operand. Consume and no accept → EMPTY. Both → ONE, main = operand.
  - TWO: consume → ONE, main = skid. No accept is possible in TWO.
- in_ready = (state != TWO). It is a registered function of state only and does not depend combinationally on bus_b_ready.
- bus_b = main, bus_b_valid = (state != EMPTY). Order is strictly FIFO. The next operand is never lost or duplicated.
- sel_err clears only on reset.

## Timing
- Reset (async assert, sync release):
  - state EMPTY, bus_b 0, bus_b_valid 0, in_ready 1, sel_err 0, last_issued 0, skid 0.
- Latency: an operand accepted in cycle N appears on bus_b with bus_b_valid in cycle N+1 when the buffer is empty.
- Throughput: 1 operand/cycle while bus_b_ready is held high.
- bus_b and bus_b_valid stay stable while bus_b_valid && !bus_b_ready.
- Full: after two accepts with no consume, in_ready drops the next cycle. The first consume raises it one cycle later.
- Simultaneous accept and consume in ONE: the occupancy count is unchanged, and bus_b shows the new operand next cycle.
- HOLD issued back-to-back with any mode uses last_issued as updated by the previous accept, not the one in flight.
- Reset asserted mid-stream discards buffered operands immediately. No partial output.

## Structure
- Shared package bus_b_pkg holds:
  - the mb encodings MB_REG=2'b00, MB_CONST=2'b01, MB_ZERO=2'b10, MB_HOLD=2'b11;
  - the state encodings EMPTY/ONE/TWO.
- Sub-module bus_b_skid (WIDTH-parametrised two-entry valid/ready skid buffer). The top contains only the source-select logic, last_issued, and sel_err.

## Test plan
- Reset: hold rst_n=0 mid-stream with two operands buffered → bus_b=0, bus_b_valid=0, in_ready=1, sel_err=0 asynchronously. A HOLD after release yields 0x00.
- Streaming, WIDTH=8, NSRC=4, bus_b_ready=1:
  - Stimulus: reg_src ports {0x11,0x22,0x33,0x44}, requests REG sel 2, CONST cs=0xA5, ZERO, HOLD on consecutive cycles.
  - Required: bus_b = 0x33, 0xA5, 0x00, 0x00 on cycles N+1..N+4.
- Back-pressure:
  - Stimulus: bus_b_ready=0, with three requests CONST 0x01, 0x02, 0x03 offered.
  - Required: the first two are accepted and in_ready=0 in the third cycle. Raising ready yields 0x01 then 0x02 then 0x03, with no loss or duplication.
- Simultaneous: in ONE holding 0x10, consume and accept CONST 0x20 in the same cycle → next cycle bus_b=0x20, state ONE, in_ready=1.
- Select error:
  - Stimulus: NSRC=3, REG sel_b=3.
  - Required: operand 0x00, sel_err=1, and sel_err stays 1 through later valid requests until reset.
- HOLD chain: REG sel 1 (0x22), then HOLD, then HOLD with reg_src changed → bus_b = 0x22, 0x22, 0x22.
